// File: rtl/stage2_wb_timed.sv
// Writeback stage of the axis_cpu controller: decodes the stage-1 instruction, waits on packet
// memory or the ALU, drives A/X/PC writeback, holds RET values on a handshake and times out stuck waits.
module stage2_wb_timed #(
    parameter int CODE_ADDR_WIDTH = 10,
    parameter int INSTR_WIDTH     = 64,
    parameter int TIMEOUT_WIDTH   = 8,
    parameter int TIMEOUT_CYCLES  = 200
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [INSTR_WIDTH-1:0]     instr_in,
    input  logic                       prev_vld,
    output logic                       rdy,
    input  logic                       mem_vld,
    input  logic                       ALU_vld,
    input  logic                       eq,
    input  logic                       gt,
    input  logic                       ge,
    input  logic                       set,
    input  logic [31:0]                A_val,
    input  logic [31:0]                X_val,
    input  logic [5:0]                 icount,
    output logic [CODE_ADDR_WIDTH-1:0] jt_out,
    output logic [CODE_ADDR_WIDTH-1:0] jf_out,
    output logic [CODE_ADDR_WIDTH-1:0] jmp_correction,
    output logic [1:0]                 PC_sel,
    output logic                       branch_mispredict,
    output logic [2:0]                 A_sel,
    output logic [2:0]                 X_sel,
    output logic                       A_en,
    output logic                       X_en,
    output logic [3:0]                 regfile_sel_stage2,
    output logic [31:0]                imm_stage2,
    output logic                       ALU_ack,
    output logic                       acc,
    output logic                       rej,
    output logic                       stage2_reads_regfile,
    output logic                       stage2_writes_A,
    output logic                       stage2_writes_X,
    output logic                       ret_vld,
    output logic [31:0]                ret_val,
    input  logic                       ret_rdy,
    output logic                       timeout_err
);

    // BPF-style opcode fields
    localparam logic [2:0] CLS_LD = 3'd0, CLS_LDX = 3'd1, CLS_ALU = 3'd4,
                           CLS_JMP = 3'd5, CLS_RET = 3'd6, CLS_MISC = 3'd7;
    localparam logic [2:0] MODE_IMM = 3'd0, MODE_ABS = 3'd1, MODE_IND = 3'd2,
                           MODE_MEM = 3'd3, MODE_LEN = 3'd4, MODE_MSH = 3'd5;
    localparam logic [3:0] JOP_JA = 4'd0, JOP_JEQ = 4'd1, JOP_JGT = 4'd2,
                           JOP_JGE = 4'd3, JOP_JSET = 4'd4;
    localparam logic [1:0] RVAL_X = 2'd1, RVAL_A = 2'd2;

    localparam logic [1:0] PC_SEL_PLUS_1 = 2'd0, PC_SEL_PLUS_JT = 2'd1,
                           PC_SEL_PLUS_JF = 2'd2, PC_SEL_PLUS_IMM = 2'd3;
    localparam logic [2:0] A_SEL_IMM = 3'd0, A_SEL_PACKET_MEM = 3'd1, A_SEL_REGFILE = 3'd2,
                           A_SEL_LEN = 3'd3, A_SEL_ALU = 3'd4, A_SEL_X = 3'd5;
    localparam logic [2:0] X_SEL_IMM = 3'd0, X_SEL_PACKET_MEM = 3'd1, X_SEL_REGFILE = 3'd2,
                           X_SEL_LEN = 3'd3, X_SEL_MSH = 3'd4, X_SEL_A = 3'd5;

    localparam logic [TIMEOUT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [31:0]              TO_LIM  = 32'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RET, S_ERR} state_t;

    state_t                   state, state_nxt;
    logic [TIMEOUT_WIDTH-1:0] wait_cnt, cnt_nxt;
    logic                     ret_load;

    logic [7:0]  op, jt, jf;
    logic [31:0] imm;
    logic [2:0]  cls, mode;
    logic [3:0]  jop;
    logic        unused_instr_hi;

    assign op   = instr_in[55:48];
    assign jt   = instr_in[47:40];
    assign jf   = instr_in[39:32];
    assign imm  = instr_in[31:0];
    assign cls  = op[2:0];
    assign mode = op[7:5];
    assign jop  = op[7:4];
    assign unused_instr_hi = ^instr_in[INSTR_WIDTH-1:56];

    logic        taken, wr_a, wr_x, is_mem, is_alu_op, is_ret, reads_rf, mispred_d;
    logic [1:0]  pc_sel_d;
    logic [2:0]  a_sel_d, x_sel_d;
    logic [31:0] ret_value;

    always_comb begin
        taken = 1'b0;
        case (jop)
            JOP_JEQ:  taken = eq;
            JOP_JGT:  taken = gt;
            JOP_JGE:  taken = ge;
            JOP_JSET: taken = set;
            default:  taken = 1'b0;
        endcase
    end

    always_comb begin
        wr_a      = 1'b0;
        wr_x      = 1'b0;
        a_sel_d   = A_SEL_IMM;
        x_sel_d   = X_SEL_IMM;
        is_mem    = 1'b0;
        is_alu_op = 1'b0;
        is_ret    = 1'b0;
        reads_rf  = 1'b0;
        pc_sel_d  = PC_SEL_PLUS_1;
        mispred_d = 1'b0;
        ret_value = imm;
        case (cls)
            CLS_LD: begin
                wr_a = 1'b1;
                case (mode)
                    MODE_IMM: a_sel_d = A_SEL_IMM;
                    MODE_ABS, MODE_IND: begin a_sel_d = A_SEL_PACKET_MEM; is_mem = 1'b1; end
                    MODE_MEM: begin a_sel_d = A_SEL_REGFILE; reads_rf = 1'b1; end
                    MODE_LEN: a_sel_d = A_SEL_LEN;
                    default:  wr_a = 1'b0;  // MSH only exists for X
                endcase
            end
            CLS_LDX: begin
                wr_x = 1'b1;
                case (mode)
                    MODE_IMM: x_sel_d = X_SEL_IMM;
                    MODE_ABS, MODE_IND: begin x_sel_d = X_SEL_PACKET_MEM; is_mem = 1'b1; end
                    MODE_MSH: begin x_sel_d = X_SEL_MSH; is_mem = 1'b1; end
                    MODE_MEM: begin x_sel_d = X_SEL_REGFILE; reads_rf = 1'b1; end
                    MODE_LEN: x_sel_d = X_SEL_LEN;
                    default:  wr_x = 1'b0;
                endcase
            end
            CLS_ALU: begin
                wr_a      = 1'b1;
                a_sel_d   = A_SEL_ALU;
                is_alu_op = 1'b1;
            end
            CLS_JMP: begin
                if (jop == JOP_JA) begin
                    pc_sel_d  = PC_SEL_PLUS_IMM;
                    mispred_d = (imm != 32'd0);
                end else if (jop == JOP_JEQ || jop == JOP_JGT || jop == JOP_JGE || jop == JOP_JSET) begin
                    is_alu_op = 1'b1;
                    pc_sel_d  = taken ? PC_SEL_PLUS_JT : PC_SEL_PLUS_JF;
                    mispred_d = taken ? (jt != 8'd0) : (jf != 8'd0);
                end
            end
            CLS_RET: begin
                is_ret = 1'b1;
                case (op[4:3])
                    RVAL_A:  ret_value = A_val;
                    RVAL_X:  ret_value = X_val;
                    default: ret_value = imm;
                endcase
            end
            CLS_MISC: begin
                if (op[7]) begin wr_a = 1'b1; a_sel_d = A_SEL_X; end
                else       begin wr_x = 1'b1; x_sel_d = X_SEL_A; end
            end
            default: ;
        endcase
    end

    logic awaiting, result_ok, hot, timeout_hit;

    assign awaiting    = prev_vld && (is_mem || is_alu_op);
    assign result_ok   = (is_mem && mem_vld) || (is_alu_op && ALU_vld);
    assign hot         = prev_vld && rdy && (state == S_IDLE || state == S_WAIT);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (32'(wait_cnt) == TO_LIM);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = wait_cnt;
        rdy       = 1'b0;
        ret_load  = 1'b0;
        case (state)
            S_IDLE: begin
                rdy = !awaiting || result_ok;
                if (prev_vld && rdy && is_ret) begin
                    ret_load  = 1'b1;
                    state_nxt = S_RET;
                end else if (awaiting && !result_ok) begin
                    state_nxt = S_WAIT;
                    cnt_nxt   = TIMEOUT_WIDTH'(1);
                end
            end
            S_WAIT: begin
                rdy = result_ok;
                // a result arriving on the timeout cycle still completes the instruction
                if (result_ok) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else if (timeout_hit) begin
                    state_nxt = S_ERR;
                end else if (wait_cnt != CNT_MAX) begin
                    cnt_nxt = wait_cnt + TIMEOUT_WIDTH'(1);
                end
            end
            S_RET:   if (ret_rdy) state_nxt = S_IDLE;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            ret_vld     <= 1'b0;
            ret_val     <= '0;
            timeout_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= cnt_nxt;
            if (ret_load) begin
                ret_vld <= 1'b1;
                ret_val <= ret_value;
            end else if (ret_vld && ret_rdy) begin
                ret_vld <= 1'b0;
            end
            if (state_nxt == S_ERR) timeout_err <= 1'b1;
        end
    end

    assign jt_out               = {{(CODE_ADDR_WIDTH-8){1'b0}}, jt};
    assign jf_out               = {{(CODE_ADDR_WIDTH-8){1'b0}}, jf};
    assign jmp_correction       = {{(CODE_ADDR_WIDTH-6){icount[5]}}, icount};
    assign PC_sel               = pc_sel_d;
    assign A_sel                = a_sel_d;
    assign X_sel                = x_sel_d;
    assign regfile_sel_stage2   = imm[3:0];
    assign imm_stage2           = imm;
    assign branch_mispredict    = hot && mispred_d;
    assign A_en                 = hot && wr_a;
    assign X_en                 = hot && wr_x;
    assign ALU_ack              = hot && is_alu_op;
    assign acc                  = hot && is_ret && (ret_value != 32'd0);
    assign rej                  = hot && is_ret && (ret_value == 32'd0);
    assign stage2_reads_regfile = prev_vld && reads_rf;
    assign stage2_writes_A      = prev_vld && wr_a;
    assign stage2_writes_X      = prev_vld && wr_x;

endmodule

// File: tb/tb_stage2_wb_timed.sv
// Bench for stage2_wb_timed: an opcode-table reference model checked every cycle, plus directed
// literal expectations around hits, waits, returns, timeout and reset.
module tb_stage2_wb_timed;

    localparam int TO = 8;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic [63:0] instr_in;
    logic        prev_vld, rdy, mem_vld, ALU_vld, eq, gt, ge, set;
    logic [31:0] A_val, X_val;
    logic [5:0]  icount;
    logic [9:0]  jt_out, jf_out, jmp_correction;
    logic [1:0]  PC_sel;
    logic        branch_mispredict, A_en, X_en, ALU_ack, acc, rej;
    logic [2:0]  A_sel, X_sel;
    logic [3:0]  regfile_sel_stage2;
    logic [31:0] imm_stage2, ret_val;
    logic        stage2_reads_regfile, stage2_writes_A, stage2_writes_X;
    logic        ret_vld, ret_rdy, timeout_err;

    logic [7:0]  t_op, t_jt, t_jf;
    logic [31:0] t_imm;
    assign instr_in = {8'h00, t_op, t_jt, t_jf, t_imm};

    stage2_wb_timed #(.CODE_ADDR_WIDTH(10), .INSTR_WIDTH(64), .TIMEOUT_WIDTH(8), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .instr_in(instr_in), .prev_vld(prev_vld), .rdy(rdy),
        .mem_vld(mem_vld), .ALU_vld(ALU_vld), .eq(eq), .gt(gt), .ge(ge), .set(set),
        .A_val(A_val), .X_val(X_val), .icount(icount), .jt_out(jt_out), .jf_out(jf_out),
        .jmp_correction(jmp_correction), .PC_sel(PC_sel), .branch_mispredict(branch_mispredict),
        .A_sel(A_sel), .X_sel(X_sel), .A_en(A_en), .X_en(X_en),
        .regfile_sel_stage2(regfile_sel_stage2), .imm_stage2(imm_stage2), .ALU_ack(ALU_ack),
        .acc(acc), .rej(rej), .stage2_reads_regfile(stage2_reads_regfile),
        .stage2_writes_A(stage2_writes_A), .stage2_writes_X(stage2_writes_X),
        .ret_vld(ret_vld), .ret_val(ret_val), .ret_rdy(ret_rdy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0;
    bit chk_en = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: per-opcode table of what the stage must do, plus a small "what is pending" state
    typedef struct packed {
        logic [1:0] pc; logic mis, wa, wx, rf, mem, alu, ret;
        logic [2:0] as, xs; logic [31:0] rv;
    } dec_t;

    typedef struct packed {
        logic rdy, hot, awaiting, ok; dec_t d;
    } exp_t;

    int          m_wait = 0;     // cycles spent waiting so far (0 = not waiting)
    bit          m_ret = 0, m_err = 0;
    logic [31:0] m_ret_val = 0;

    function automatic dec_t decode(input logic [7:0] op);
        dec_t d = '0;
        case (op)
            8'h00: d.wa = 1;                                            // LD #k
            8'h20, 8'h40: begin d.wa = 1; d.as = 1; d.mem = 1; end      // LD [k] / [x+k]
            8'h60: begin d.wa = 1; d.as = 2; d.rf = 1; end              // LD M[k]
            8'h80: begin d.wa = 1; d.as = 3; end                        // LD len
            8'h01: d.wx = 1;
            8'h21, 8'h41: begin d.wx = 1; d.xs = 1; d.mem = 1; end
            8'hA1: begin d.wx = 1; d.xs = 4; d.mem = 1; end             // LDX 4*([k]&0xf)
            8'h61: begin d.wx = 1; d.xs = 2; d.rf = 1; end
            8'h81: begin d.wx = 1; d.xs = 3; end
            8'h04, 8'h0C: begin d.wa = 1; d.as = 4; d.alu = 1; end      // ADD k / ADD x
            8'h05: begin d.pc = 3; d.mis = (t_imm != 0); end            // JA
            8'h15, 8'h25, 8'h35, 8'h45: begin
                logic tk;
                d.alu = 1;
                tk = (op == 8'h15) ? eq : (op == 8'h25) ? gt : (op == 8'h35) ? ge : set;
                d.pc  = tk ? 2'd1 : 2'd2;
                d.mis = tk ? (t_jt != 0) : (t_jf != 0);
            end
            8'h06: begin d.ret = 1; d.rv = t_imm; end
            8'h0E: begin d.ret = 1; d.rv = X_val; end
            8'h16: begin d.ret = 1; d.rv = A_val; end
            8'h07: begin d.wx = 1; d.xs = 5; end                        // TAX
            8'h87: begin d.wa = 1; d.as = 5; end                        // TXA
            default: ;
        endcase
        return d;
    endfunction

    function automatic exp_t evaluate();
        exp_t e;
        e.d        = decode(t_op);
        e.awaiting = prev_vld && (e.d.mem || e.d.alu);
        e.ok       = (e.d.mem && mem_vld) || (e.d.alu && ALU_vld);
        if (m_err || m_ret) e.rdy = 0;
        else if (m_wait > 0) e.rdy = e.ok;
        else e.rdy = !e.awaiting || e.ok;
        e.hot = prev_vld && e.rdy && !m_err && !m_ret;
        return e;
    endfunction

    always @(posedge clk) begin
        exp_t e;
        e = evaluate();
        if (!rst_n) begin
            m_wait <= 0; m_ret <= 0; m_err <= 0; m_ret_val <= 0;
        end else if (m_err) begin
        end else if (m_ret) begin
            if (ret_rdy) m_ret <= 0;
        end else if (m_wait > 0) begin
            if (e.ok) m_wait <= 0;
            else if (m_wait == TO) m_err <= 1;
            else m_wait <= m_wait + 1;
        end else if (e.hot && e.d.ret) begin
            m_ret <= 1; m_ret_val <= e.d.rv;
        end else if (e.awaiting && !e.ok) begin
            m_wait <= 1;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (chk_en) begin
            e = evaluate();
            chk("rdy", 64'(rdy), 64'(e.rdy));
            chk("PC_sel", 64'(PC_sel), 64'(e.d.pc));
            chk("branch_mispredict", 64'(branch_mispredict), 64'(e.hot && e.d.mis));
            chk("A_en", 64'(A_en), 64'(e.hot && e.d.wa));
            chk("X_en", 64'(X_en), 64'(e.hot && e.d.wx));
            chk("A_sel", 64'(A_sel), 64'(e.d.as));
            chk("X_sel", 64'(X_sel), 64'(e.d.xs));
            chk("ALU_ack", 64'(ALU_ack), 64'(e.hot && e.d.alu));
            chk("acc", 64'(acc), 64'(e.hot && e.d.ret && e.d.rv != 0));
            chk("rej", 64'(rej), 64'(e.hot && e.d.ret && e.d.rv == 0));
            chk("writes_A", 64'(stage2_writes_A), 64'(prev_vld && e.d.wa));
            chk("writes_X", 64'(stage2_writes_X), 64'(prev_vld && e.d.wx));
            chk("reads_regfile", 64'(stage2_reads_regfile), 64'(prev_vld && e.d.rf));
            chk("jt_out", 64'(jt_out), 64'(t_jt));
            chk("jf_out", 64'(jf_out), 64'(t_jf));
            chk("jmp_correction", 64'(jmp_correction), 64'($signed(icount)) & 64'h3FF);
            chk("regfile_sel", 64'(regfile_sel_stage2), 64'(t_imm % 16));
            chk("imm_stage2", 64'(imm_stage2), 64'(t_imm));
            chk("ret_vld", 64'(ret_vld), 64'(m_ret));
            chk("ret_val", 64'(ret_val), 64'(m_ret_val));
            chk("timeout_err", 64'(timeout_err), 64'(m_err));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic put(input logic [7:0] op, input logic [7:0] jt, input logic [7:0] jf,
                       input logic [31:0] imm);
        t_op = op; t_jt = jt; t_jf = jf; t_imm = imm; prev_vld = 1;
    endtask

    task automatic idle_in();
        prev_vld = 0; mem_vld = 0; ALU_vld = 0; eq = 0; gt = 0; ge = 0; set = 0;
        t_op = 8'h02; t_jt = 0; t_jf = 0; t_imm = 0;
    endtask

    initial begin
        idle_in();
        A_val = 0; X_val = 0; icount = 0; ret_rdy = 0;
        step(1);
        chk_en = 1;
        step(1);
        at_neg();
        chk("reset rdy", 64'(rdy), 64'd1);
        chk("reset ret_vld", 64'(ret_vld), 64'd0);
        chk("reset timeout_err", 64'(timeout_err), 64'd0);
        rst_n = 1;
        step(1);

        // JEQ hit with ALU result in the same cycle
        put(8'h15, 8'd3, 8'd5, 32'h0); ALU_vld = 1; eq = 1; icount = 6'h3E;
        at_neg();
        chk("jeq rdy", 64'(rdy), 64'd1);
        chk("jeq PC_sel", 64'(PC_sel), 64'd1);
        chk("jeq mispredict", 64'(branch_mispredict), 64'd1);
        chk("jeq ALU_ack", 64'(ALU_ack), 64'd1);
        chk("jeq jmp_correction", 64'(jmp_correction), 64'h3FE);
        step(1); idle_in();
        at_neg();
        chk("jeq ack drop", 64'(ALU_ack), 64'd0);
        step(1);
        put(8'h25, 8'd2, 8'd0, 32'h0); ALU_vld = 1; icount = 6'd5;   // JGT not taken, jf=0
        at_neg();
        chk("jgt PC_sel", 64'(PC_sel), 64'd2);
        chk("jgt mispredict", 64'(branch_mispredict), 64'd0);
        step(1); idle_in();
        put(8'h05, 8'd0, 8'd0, 32'd7);
        at_neg();
        chk("ja PC_sel", 64'(PC_sel), 64'd3);
        step(1); idle_in();

        // LD ABS with memory 4 cycles late
        put(8'h20, 0, 0, 32'h10);
        for (int i = 0; i < 4; i++) begin
            at_neg();
            chk("ld wait rdy", 64'(rdy), 64'd0);
            step(1);
        end
        mem_vld = 1;
        at_neg();
        chk("ld A_en", 64'(A_en), 64'd1);
        chk("ld A_sel", 64'(A_sel), 64'd1);
        step(1); idle_in();
        at_neg();
        chk("ld back idle rdy", 64'(rdy), 64'd1);

        put(8'hA1, 0, 0, 32'h0E); mem_vld = 1; step(1); idle_in();
        X_val = 32'h33; A_val = 32'h44;
        put(8'h07, 0, 0, 0); step(1);
        put(8'h87, 0, 0, 0); step(1);
        put(8'h61, 0, 0, 32'h9); step(1);
        put(8'h81, 0, 0, 0); step(1);
        put(8'h0C, 0, 0, 0); step(2); ALU_vld = 1; step(1); idle_in();

        // RETA with a slow consumer; a TAX queues behind it
        A_val = 32'h5EA; put(8'h16, 0, 0, 32'h1);
        at_neg();
        chk("reta acc", 64'(acc), 64'd1);
        chk("reta rej", 64'(rej), 64'd0);
        step(1);
        put(8'h07, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            at_neg();
            chk("ret hold vld", 64'(ret_vld), 64'd1);
            chk("ret hold val", 64'(ret_val), 64'h5EA);
            chk("ret hold rdy", 64'(rdy), 64'd0);
            step(1);
        end
        ret_rdy = 1;
        at_neg();
        chk("ret accept vld", 64'(ret_vld), 64'd1);
        step(1); ret_rdy = 0;
        at_neg();
        chk("ret done vld", 64'(ret_vld), 64'd0);
        chk("ret done rdy", 64'(rdy), 64'd1);
        step(1); idle_in();

        X_val = 0; put(8'h0E, 0, 0, 32'h9); step(1); idle_in(); ret_rdy = 1; step(1); ret_rdy = 0;
        put(8'h06, 0, 0, 32'h0);
        at_neg();
        chk("retk0 rej", 64'(rej), 64'd1);
        chk("retk0 acc", 64'(acc), 64'd0);
        step(1); idle_in();
        at_neg();
        chk("retk0 val", 64'(ret_val), 64'd0);
        chk("retk0 vld", 64'(ret_vld), 64'd1);
        ret_rdy = 1; step(1); ret_rdy = 0;

        // reset in the middle of WAIT, then in the middle of RET
        put(8'h04, 0, 0, 0); step(3);
        rst_n = 0; step(1); rst_n = 1;
        at_neg();
        chk("rst wait ack", 64'(ALU_ack), 64'd0);
        chk("rst wait rdy", 64'(rdy), 64'd0);
        ALU_vld = 1;
        at_neg();
        chk("rst wait resume ack", 64'(ALU_ack), 64'd1);
        step(1); idle_in();
        A_val = 32'h77; put(8'h16, 0, 0, 0); step(1); idle_in();
        rst_n = 0; step(1); rst_n = 1;
        at_neg();
        chk("rst ret drop", 64'(ret_vld), 64'd0);

        // result on the last allowed WAIT cycle beats the timeout
        put(8'h04, 0, 0, 0); step(TO);
        ALU_vld = 1;
        at_neg();
        chk("late ok rdy", 64'(rdy), 64'd1);
        step(1); idle_in();
        at_neg();
        chk("late ok no err", 64'(timeout_err), 64'd0);

        // ALU never answers
        put(8'h0C, 0, 0, 0); step(TO);
        at_neg();
        chk("pre timeout err", 64'(timeout_err), 64'd0);
        step(1);
        at_neg();
        chk("timeout err", 64'(timeout_err), 64'd1);
        chk("timeout rdy", 64'(rdy), 64'd0);
        ALU_vld = 1;
        at_neg();
        chk("err ignores ALU", 64'(ALU_ack), 64'd0);
        step(2);
        at_neg();
        chk("err sticky", 64'(timeout_err), 64'd1);
        idle_in(); rst_n = 0; step(1); rst_n = 1;
        at_neg();
        chk("err cleared", 64'(timeout_err), 64'd0);
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
